// File: rtl/regfile.sv
// Integer register file: x0 reads zero, one write port, two bypassed async reads, one debug read.
// Latency: write 1 edge to storage, 0 on RD1/RD2 via bypass; no backpressure, accepts a write every cycle.
module regfile #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWrite_W,
  input  logic [4:0]      Rd_W,
  input  logic [XLEN-1:0] Result_W,
  input  logic [4:0]      A1_D,
  input  logic [4:0]      A2_D,
  output logic [XLEN-1:0] RD1_D,
  output logic [XLEN-1:0] RD2_D,
  input  logic [4:0]      DbgAddr,
  output logic [XLEN-1:0] DbgData,
  output logic [XLEN-1:0] WriteCount
);

  // x0 has no entry; every read path masks address 0 before indexing.
  logic [XLEN-1:0] regs [1:NREGS-1];
  logic            commit;

  assign commit = RegWrite_W && (Rd_W != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[Rd_W] <= Result_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WriteCount <= '0;
    end else if (commit) begin
      WriteCount <= WriteCount + {{(XLEN-1){1'b0}}, 1'b1};
    end
  end

  // Same-cycle bypass lets Decode see the Writeback result without a forwarding path.
  always_comb begin
    RD1_D = '0;
    if (A1_D != 5'd0) begin
      if (RegWrite_W && (Rd_W == A1_D)) begin
        RD1_D = Result_W;
      end else begin
        RD1_D = regs[A1_D];
      end
    end
  end

  always_comb begin
    RD2_D = '0;
    if (A2_D != 5'd0) begin
      if (RegWrite_W && (Rd_W == A2_D)) begin
        RD2_D = Result_W;
      end else begin
        RD2_D = regs[A2_D];
      end
    end
  end

  always_comb begin
    DbgData = '0;
    if (DbgAddr != 5'd0) begin
      DbgData = regs[DbgAddr];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: 64-bit instance for function, 4-bit instance for counter wrap.
module tb_regfile;

  logic        clk;
  logic        rst_n;

  logic        we;
  logic [4:0]  rd;
  logic [63:0] res;
  logic [4:0]  a1, a2, dbg_addr;
  logic [63:0] rd1, rd2, dbg_data, wcount;

  logic        s_we;
  logic [4:0]  s_rd;
  logic [3:0]  s_res;
  logic [4:0]  s_a1, s_a2, s_dbg_addr;
  logic [3:0]  s_rd1, s_rd2, s_dbg_data, s_wcount;

  int checks = 0;
  int errors = 0;

  regfile dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_W(we), .Rd_W(rd), .Result_W(res),
    .A1_D(a1), .A2_D(a2), .RD1_D(rd1), .RD2_D(rd2),
    .DbgAddr(dbg_addr), .DbgData(dbg_data), .WriteCount(wcount)
  );

  regfile #(.XLEN(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_W(s_we), .Rd_W(s_rd), .Result_W(s_res),
    .A1_D(s_a1), .A2_D(s_a2), .RD1_D(s_rd1), .RD2_D(s_rd2),
    .DbgAddr(s_dbg_addr), .DbgData(s_dbg_data), .WriteCount(s_wcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge so the next rising edge commits them.
  task automatic drive(input logic w, input logic [4:0] r, input logic [63:0] v);
    @(negedge clk);
    we  = w;
    rd  = r;
    res = v;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    we = 1'b0; rd = '0; res = '0; a1 = '0; a2 = '0; dbg_addr = '0;
    s_we = 1'b0; s_rd = '0; s_res = '0; s_a1 = '0; s_a2 = '0; s_dbg_addr = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    a1 = 5'd5; a2 = 5'd31; dbg_addr = 5'd5;
    #1;
    check("rst_count", wcount, 64'd0);
    check("rst_rd1", rd1, 64'd0);
    check("rst_rd2", rd2, 64'd0);
    check("rst_dbg", dbg_data, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read
    a1 = 5'd3; dbg_addr = 5'd3;
    drive(1'b1, 5'd3, 64'hAAAA_AAAA_AAAA_AAAA);
    check("basic_bypass_rd1", rd1, 64'hAAAA_AAAA_AAAA_AAAA);
    check("basic_dbg_before", dbg_data, 64'd0);
    drive(1'b0, 5'd0, 64'd0);
    check("basic_rd1", rd1, 64'hAAAA_AAAA_AAAA_AAAA);
    check("basic_dbg", dbg_data, 64'hAAAA_AAAA_AAAA_AAAA);
    check("basic_count", wcount, 64'd1);

    // x0 discard
    a1 = 5'd0; a2 = 5'd0;
    drive(1'b1, 5'd0, 64'hBBBB_BBBB_BBBB_BBBB);
    check("x0_rd1_bypass", rd1, 64'd0);
    check("x0_rd2_bypass", rd2, 64'd0);
    drive(1'b0, 5'd0, 64'd0);
    dbg_addr = 5'd0;
    #1;
    check("x0_rd1", rd1, 64'd0);
    check("x0_dbg", dbg_data, 64'd0);
    check("x0_count", wcount, 64'd1);

    // Bypass on both ports while debug still shows committed state
    drive(1'b1, 5'd7, 64'h1000);
    a1 = 5'd7; a2 = 5'd7; dbg_addr = 5'd7;
    drive(1'b1, 5'd7, 64'h1004);
    check("byp_rd1", rd1, 64'h1004);
    check("byp_rd2", rd2, 64'h1004);
    check("byp_dbg_before", dbg_data, 64'h1000);
    drive(1'b0, 5'd0, 64'd0);
    check("byp_dbg_after", dbg_data, 64'h1004);
    check("byp_count", wcount, 64'd3);

    // Bypass on one port only
    a1 = 5'd7; a2 = 5'd3;
    drive(1'b1, 5'd3, 64'h55);
    check("byp1_rd1_nohit", rd1, 64'h1004);
    check("byp1_rd2_hit", rd2, 64'h55);

    // Back-to-back writes to x9
    drive(1'b1, 5'd9, 64'd1);
    drive(1'b1, 5'd9, 64'd2);
    drive(1'b0, 5'd0, 64'd0);
    dbg_addr = 5'd9; a1 = 5'd9;
    #1;
    check("b2b_dbg", dbg_data, 64'd2);
    check("b2b_rd1", rd1, 64'd2);
    check("b2b_count", wcount, 64'd6);

    // Disabled write: no commit, no bypass, no count
    a1 = 5'd12; dbg_addr = 5'd12;
    drive(1'b0, 5'd12, 64'hDEAD);
    check("nowe_rd1", rd1, 64'd0);
    drive(1'b0, 5'd0, 64'd0);
    check("nowe_dbg", dbg_data, 64'd0);
    check("nowe_count", wcount, 64'd6);

    // Reset mid-operation
    drive(1'b1, 5'd5, 64'h1234);
    drive(1'b0, 5'd0, 64'd0);
    dbg_addr = 5'd5; a1 = 5'd5; a2 = 5'd3;
    #1;
    check("mid_dbg_pre", dbg_data, 64'h1234);
    check("mid_count_pre", wcount, 64'd7);
    rst_n = 1'b0;
    #1;
    check("mid_dbg", dbg_data, 64'd0);
    check("mid_count", wcount, 64'd0);
    check("mid_rd1", rd1, 64'd0);
    check("mid_rd2_x3", rd2, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b1; rd = 5'd4; res = 64'h42;
    dbg_addr = 5'd4;
    drive(1'b0, 5'd0, 64'd0);
    check("first_commit_dbg", dbg_data, 64'h42);
    check("first_commit_count", wcount, 64'd1);

    // Counter wrap on the 4-bit instance: 15 writes, then two more
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      s_we = 1'b1;
      s_rd = 5'(1 + i);
      s_res = 4'(i);
    end
    @(negedge clk);
    s_we = 1'b0;
    #1;
    check("wrap_count15", {60'd0, s_wcount}, 64'd15);
    s_dbg_addr = 5'd10;
    s_a1 = 5'd10; s_a2 = 5'd20;
    #1;
    check("small_dbg", {60'd0, s_dbg_data}, 64'd9);
    s_we = 1'b1; s_rd = 5'd20; s_res = 4'hC;
    #1;
    check("small_rd1", {60'd0, s_rd1}, 64'd9);
    check("small_rd2_byp", {60'd0, s_rd2}, 64'hC);
    @(negedge clk);
    s_we = 1'b0;
    #1;
    check("wrap_count0", {60'd0, s_wcount}, 64'd0);
    @(negedge clk);
    s_we = 1'b1; s_rd = 5'd21; s_res = 4'h3;
    @(negedge clk);
    s_we = 1'b0;
    #1;
    check("wrap_count1", {60'd0, s_wcount}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
